// File: rtl/c2h_readback_streamer_pkg.sv
// Shared encodings and defaults for the C2H readback streamer.
package readback_pkg;

    localparam int XDMA_AXI_DATA_WIDTH = 256;
    localparam int PKT_BEATS_DEFAULT   = 16;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        PAD   = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic {
        STREAM = 1'b0,
        BATCH  = 1'b1
    } mode_t;

endpackage

// File: rtl/c2h_readback_streamer_if.sv
// XDMA card-to-host AXI-stream channel 0; master drives data, slave drives ready.
interface c2h_readback_streamer_if
    import readback_pkg::*;
#(
    parameter int DATA_WIDTH = XDMA_AXI_DATA_WIDTH
);
    logic [DATA_WIDTH-1:0]   c2h_tdata_0;
    logic                    c2h_tvalid_0;
    logic                    c2h_tready_0;
    logic                    c2h_tlast_0;
    logic [DATA_WIDTH/8-1:0] c2h_tkeep_0;

    modport master (
        output c2h_tdata_0, c2h_tvalid_0, c2h_tlast_0, c2h_tkeep_0,
        input  c2h_tready_0
    );

    modport slave (
        input  c2h_tdata_0, c2h_tvalid_0, c2h_tlast_0, c2h_tkeep_0,
        output c2h_tready_0
    );
endinterface

// File: rtl/c2h_readback_streamer_fifo.sv
// First-word-fall-through FIFO; extra pointer MSB distinguishes full from empty.
module readback_fifo #(
    parameter int WIDTH = 256,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     wr_en,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             push;
    logic             pop;

    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty   = (wptr == rptr);
    assign count   = wptr - rptr;
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + (AW+1)'(1);
            if (pop)  rptr <= rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= wr_data;
    end
endmodule

// File: rtl/c2h_readback_streamer.sv
// Packs DRAM read-return words into fixed-length C2H packets, with STREAM/BATCH
// gating and an end-of-program flush that pads the open packet if needed.
module c2h_readback_streamer
    import readback_pkg::*;
#(
    parameter int DATA_WIDTH = XDMA_AXI_DATA_WIDTH,
    parameter int FIFO_DEPTH = 64,
    parameter int PKT_BEATS  = PKT_BEATS_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_WIDTH-1:0]         rd_data,
    input  logic                          rd_valid,
    output logic                          rd_ready,
    input  logic                          rbe_switch_mode,
    input  logic                          softmc_fin,
    c2h_readback_streamer_if.master       c2h,
    output logic                          readback_done,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level
);
    // state | meaning
    // RUN   | normal packing, mode-gated
    // FLUSH | drain FIFO regardless of mode, tlast on emptying beat
    // PAD   | zero beat closing a partial packet
    // DONE  | pulse readback_done, clear beat counter
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(PKT_BEATS);

    state_t          state, state_nxt;
    mode_t           mode, mode_eff;
    logic            pending;
    logic            holding;
    logic            last_q;
    logic [BW-1:0]   beat_ctr;

    logic [DATA_WIDTH-1:0] head;
    logic            full, empty;
    logic [AW:0]     count;
    logic            push_ok, pop, hs, will_empty;
    logic            boundary_flip, offer, last_now;
    logic            tvalid, tlast;

    readback_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_data (rd_data),
        .wr_en   (rd_valid),
        .rd_en   (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    // A stalled beat (holding) is frozen: no mode flip, tlast latched in last_q.
    assign boundary_flip = pending && (beat_ctr == '0) && !holding;
    assign mode_eff      = boundary_flip ? mode_t'(~mode) : mode;

    always_comb begin
        offer    = 1'b0;
        last_now = (beat_ctr == BW'(PKT_BEATS-1));
        case (state)
            RUN:   offer = !empty && (mode_eff == STREAM || beat_ctr != '0 ||
                                      count >= (AW+1)'(PKT_BEATS));
            FLUSH: begin
                offer    = !empty;
                last_now = last_now || (count == (AW+1)'(1));
            end
            PAD: begin
                offer    = 1'b1;
                last_now = 1'b1;
            end
            default: offer = 1'b0;
        endcase
    end

    assign tvalid     = holding || offer;
    assign tlast      = tvalid && (holding ? last_q : last_now);
    assign hs         = tvalid && c2h.c2h_tready_0;
    assign pop        = hs && (state != PAD);
    assign push_ok    = rd_valid && !full;
    assign will_empty = (count == (AW+1)'(1)) && pop && !push_ok;

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:   if (softmc_fin) state_nxt = FLUSH;
            FLUSH: begin
                if (hs && tlast && will_empty)
                    state_nxt = DONE;
                else if (empty && !tvalid)
                    state_nxt = (beat_ctr == '0) ? DONE : PAD;
            end
            PAD:   if (hs) state_nxt = DONE;
            DONE:  state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= RUN;
            mode     <= STREAM;
            pending  <= 1'b0;
            holding  <= 1'b0;
            last_q   <= 1'b0;
            beat_ctr <= '0;
            overflow <= 1'b0;
        end else begin
            state   <= state_nxt;
            mode    <= mode_eff;
            pending <= boundary_flip ? rbe_switch_mode : (pending ^ rbe_switch_mode);
            holding <= tvalid && !c2h.c2h_tready_0;
            last_q  <= tlast;
            if (state == DONE)
                beat_ctr <= '0;
            else if (hs)
                beat_ctr <= tlast ? '0 : beat_ctr + BW'(1);
            if (rd_valid && full)
                overflow <= 1'b1;
        end
    end

    assign c2h.c2h_tvalid_0 = tvalid;
    assign c2h.c2h_tlast_0  = tlast;
    assign c2h.c2h_tdata_0  = (tvalid && state != PAD) ? head : '0;
    assign c2h.c2h_tkeep_0  = '1;
    assign rd_ready         = !full;
    assign readback_done    = (state == DONE);
    assign fill_level       = count;
endmodule

// File: doc/c2h_readback_streamer.md
# c2h_readback_streamer

- Returns DRAM read data to the host over the XDMA card-to-host (C2H) AXI-stream channel 0; the host-to-card channel already loads the instruction memory.
- Buffers words from the read-return path in a FIFO and packs them into fixed-length C2H packets with correct `tlast` framing.
- Supports two readback modes, toggled by `rbe_switch_mode`.
- Drains and closes the open packet when `softmc_fin` marks the end of a program.

## Interface
Clocking and reset: one clock; reset is synchronous and active-low (`clk`, `rst_n`).

Parameters:
- `DATA_WIDTH`, default `XDMA_AXI_DATA_WIDTH` (256): read word and C2H beat width.
- `FIFO_DEPTH`, default 64: buffer depth in words; must be a power of two.
- `PKT_BEATS`, default 16: beats per C2H packet; range 2..`FIFO_DEPTH`.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: synchronous, active-low reset.
- `rd_data` in `DATA_WIDTH`: read-return word.
- `rd_valid` in 1: `rd_data` valid.
- `rd_ready` out 1: FIFO can accept a word.
- `rbe_switch_mode` in 1: one-cycle pulse that toggles the readback mode.
- `softmc_fin` in 1: one-cycle pulse marking end of program; starts the flush.
- `c2h_tdata_0` out `DATA_WIDTH`: stream data.
- `c2h_tvalid_0` out 1: stream valid.
- `c2h_tready_0` in 1: stream ready from XDMA.
- `c2h_tlast_0` out 1: last beat of a packet.
- `c2h_tkeep_0` out `DATA_WIDTH/8`: byte enables; always all-ones.
- `readback_done` out 1: one-cycle pulse once the flush completes.
- `overflow` out 1: sticky; set when a word was dropped.
- `fill_level` out `log2(FIFO_DEPTH)+1`: current FIFO occupancy.

## Operation
Modes:
- `STREAM` is the reset default: a beat is offered whenever the FIFO is non-empty.
- `BATCH`: a packet starts only when `fill_level >= PKT_BEATS`; the whole packet then goes out back-to-back, subject to `tready`.
- A `rbe_switch_mode` pulse sets a pending-toggle flag.
  - The mode flips when `beat_ctr == 0` (packet boundary).
  - Two pulses before that boundary cancel each other.

Beat counter:
- `beat_ctr` counts 0..`PKT_BEATS-1` and increments on each handshake (`tvalid && tready`).
- `tlast = (beat_ctr == PKT_BEATS-1)` in `RUN`.
- `beat_ctr` wraps to 0 after the last beat.

State machine:
- `RUN`
  - `softmc_fin` -> `FLUSH`.
- `FLUSH`
  - Words keep arriving; packets are sent regardless of mode.
  - `tlast` is also asserted on any beat that empties the FIFO.
  - FIFO empty and `beat_ctr == 0` -> `DONE`.
  - FIFO empty, `beat_ctr != 0`, and no beat currently presented -> `PAD`.
- `PAD`
  - Presents one beat: data 0, `tkeep` all-ones, `tlast` = 1.
  - On handshake -> `DONE`.
- `DONE`
  - Pulses `readback_done` for one cycle.
  - Clears `beat_ctr` -> `RUN`.

`softmc_fin` outside `RUN` is ignored.

FIFO rules:
- `rd_ready = !full`.
- `rd_valid && !rd_ready` sets `overflow`. The read path does not stall, so that word is lost. Only reset clears `overflow`.
- Push and pop in the same cycle leave `fill_level` unchanged.
- `rd_ready` is not raised by a same-cycle pop when full.
- Pointers are `log2(FIFO_DEPTH)+1` bits: full is MSB differ / rest equal; empty is all equal.

AXI rules:
- Once `tvalid` is asserted, `tdata` and `tlast` hold until handshake.
- `tvalid` never drops without a handshake, except on reset.

## Timing
- Reset values:
  - `c2h_tvalid_0` = 0.
  - `c2h_tlast_0` = 0.
  - `c2h_tdata_0` = 0.
  - `c2h_tkeep_0` = all-ones.
  - `rd_ready` = 1.
  - `readback_done` = 0.
  - `overflow` = 0.
  - `fill_level` = 0.
  - State = `RUN`, mode = `STREAM`, pending-toggle = 0.
- Latency: a word written at edge N is presented with `tvalid` in cycle N+1 (STREAM mode, output idle).
- Throughput: 1 beat/cycle with `tready` held high.
- `readback_done` is high in the cycle after the final (or pad) handshake.
- With an empty FIFO and `beat_ctr == 0` at `softmc_fin`, `readback_done` is high 2 cycles after the pulse.
- Reset mid-packet: state, counters, FIFO and flags all return to reset values at the next edge. The partial packet is discarded.

## Structure
- The shared package `readback_pkg` holds:
  - state encodings: `RUN`=0, `FLUSH`=1, `PAD`=2, `DONE`=3;
  - mode encodings: `STREAM`=0, `BATCH`=1;
  - the `PKT_BEATS` default.
- One sub-module, `readback_fifo`: synchronous first-word-fall-through FIFO with full, empty and count outputs, parameterised by width and depth.
- Framing, mode and FSM logic live in the top module.

## Test plan
- **Stream burst:** reset, then push 32 words (values 0..31) with `tready`=1. Expect 32 beats in order, `tlast` on beats 15 and 31, zero stalls.
- **Batch gating:**
  - Pulse `rbe_switch_mode`, then push 15 words. Expect no `tvalid`.
  - Push the 16th word. Expect 16 consecutive beats with `tlast` on the 16th.
- **Flush with pad:**
  - Push 5 words, drain them, then pulse `softmc_fin`. Expect one zero pad beat with `tlast` = 1.
  - Expect `readback_done` one cycle after the pad handshake.
- **Backpressure:**
  - Toggle `tready` at random, 50% duty, over 200 words. Expect data and `tlast` stable while stalled, no loss, and order preserved.
  - Drop `tready` indefinitely and push 70 words. Expect `rd_ready`=0 after 64, and `overflow`=1 on the 65th push attempt.
- **Mode switch mid-packet:** in STREAM mode, pulse `rbe_switch_mode` at beat 7. Expect the packet to finish as STREAM and BATCH gating to start on the next packet; a double pulse leaves STREAM unchanged.
- **Reset mid-packet:** assert `rst_n`=0 during beat 9. Expect all outputs at reset values on the next edge, and a fresh packet starting at `beat_ctr` 0.
